move_sequencer: RTL

- Per-move scheduler that feeds the per-axis jerk/accel step-profile generators.
- Buffers complete multi-axis move commands in a small FIFO and loads each move's 5-word parameter set into the enabled generators.
- Holds their start lines high until every enabled axis reports finish, then forces start low so the generators re-arm before the next move.
- Sits between the command/host interface and the generator array.

---
 rtl/jas_pkg.sv | 29 ++
 rtl/move_fifo.sv | 60 ++++++
 rtl/move_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/jas_pkg.sv
// Shared types and constants for the move sequencer and its move FIFO.
// A move carries an axis-enable mask plus one 5-word profile parameter set per axis.
package jas_pkg;

    localparam int NUM_PARAMS = 5;

    // Word index of each profile parameter within one axis' parameter set
    localparam int P_N     = 0;
    localparam int P_NN    = 1;
    localparam int P_T0    = 2;
    localparam int P_TNA   = 3;
    localparam int P_DELTA = 4;

    localparam int DEF_AXES = 3;
    localparam int DEF_PW   = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        RELEASE = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [DEF_AXES-1:0]                   mask;
        logic [DEF_AXES*NUM_PARAMS*DEF_PW-1:0] params;
    } move_t;

endpackage

// File: rtl/move_fifo.sv
// Circular move buffer with push/pop/flush and occupancy count.
// The head entry is visible on rd_data so the consumer can capture it on the pop edge.
module move_fifo
    import jas_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = move_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  entry_t                 wr_data,
    output entry_t                 rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            push_ok_s;
    logic            pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign rd_data   = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer and occupancy bookkeeping; flush drops every stored move
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= wr_data;
    end

endmodule

// File: rtl/move_sequencer.sv
// Per-move scheduler: queues multi-axis moves and hands each to the step-profile
// generators, holding start high until every enabled axis reports finish.
module move_sequencer
    import jas_pkg::*;
#(
    parameter int AXES  = 3,
    parameter int DEPTH = 4,
    parameter int PW    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [AXES-1:0]              cmd_mask,
    input  logic [AXES*NUM_PARAMS*PW-1:0] cmd_params,
    input  logic                         estop,
    output logic [AXES*NUM_PARAMS*PW-1:0] gen_params,
    output logic [AXES-1:0]              gen_start,
    input  logic [AXES-1:0]              gen_finish,
    output logic                         busy,
    output logic                         move_done,
    output logic                         aborted,
    output logic [$clog2(DEPTH):0]       queue_level,
    output logic [15:0]                  moves_done
);

    localparam int PARW = AXES*NUM_PARAMS*PW;

    typedef struct packed {
        logic [AXES-1:0] mask;
        logic [PARW-1:0] params;
    } move_entry_t;

    seq_state_t           state_r;
    seq_state_t           state_next_s;
    logic [AXES-1:0]      active_mask_r;
    logic [PARW-1:0]      gen_params_r;
    logic [AXES-1:0]      gen_start_r;
    logic                 move_done_r;
    logic                 aborted_r;
    logic [15:0]          moves_done_r;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [$clog2(DEPTH):0] fifo_count_s;
    move_entry_t          wr_entry_s;
    move_entry_t          head_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 launch_s;
    logic                 complete_s;
    logic                 all_done_s;

    // estop closes the input so a command offered in the abort cycle is dropped
    assign cmd_ready   = !fifo_full_s && !estop;
    assign push_s      = cmd_valid && cmd_ready;
    assign wr_entry_s  = {cmd_mask, cmd_params};
    assign all_done_s  = &(gen_finish | ~active_mask_r);

    assign gen_params  = gen_params_r;
    assign gen_start   = gen_start_r;
    assign move_done   = move_done_r;
    assign aborted     = aborted_r;
    assign moves_done  = moves_done_r;
    assign queue_level = fifo_count_s;
    assign busy        = (state_r != IDLE) || !fifo_empty_s;

    move_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (move_entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (estop),
        .wr_data (wr_entry_s),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_next_s;
    end

    // Next-state and per-edge control strobes; estop overrides every state
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        launch_s     = 1'b0;
        complete_s   = 1'b0;
        if (estop) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        pop_s        = 1'b1;
                        state_next_s = LOAD;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                LOAD: begin
                    // An empty mask has nothing to wait for and completes immediately
                    if (active_mask_r == {AXES{1'b0}}) begin
                        complete_s   = 1'b1;
                        state_next_s = RELEASE;
                    end else begin
                        launch_s     = 1'b1;
                        state_next_s = RUN;
                    end
                end
                RUN: begin
                    if (all_done_s) begin
                        complete_s   = 1'b1;
                        state_next_s = RELEASE;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                RELEASE: state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Registered generator interface, status pulses and completion counter
    always_ff @(posedge clk) begin
        if (reset) begin
            active_mask_r <= {AXES{1'b0}};
            gen_params_r  <= {PARW{1'b0}};
            gen_start_r   <= {AXES{1'b0}};
            move_done_r   <= 1'b0;
            aborted_r     <= 1'b0;
            moves_done_r  <= 16'd0;
        end else begin
            move_done_r <= complete_s;
            aborted_r   <= estop;
            if (pop_s) begin
                gen_params_r  <= head_s.params;
                active_mask_r <= head_s.mask;
            end
            if (estop || complete_s) gen_start_r <= {AXES{1'b0}};
            else if (launch_s)       gen_start_r <= active_mask_r;
            if (complete_s) moves_done_r <= moves_done_r + 16'd1;
        end
    end

endmodule
